// File: rtl/bk_ps2_keyboard.sv
// PS/2 set-2 keyboard front-end for the BK keyboard register: sync/filter, frame receiver, prefix decode, key map.
// Code appears ~2 ce after the stop-bit edge is filtered; one pending code is held, and later makes are dropped until read_kbd rises.
module bk_ps2_keyboard #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 2047
) (
  input  logic       m_clock,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       read_kbd,
  output logic [7:0] kbd_data,
  output logic       kbd_available,
  output logic       kbd_ar2,
  output logic       stopkey,
  output logic       keydown,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {R_IDLE, R_BITS, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_NONE, P_EXT, P_BRK, P_EXTBRK} pf_state_t;

  logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall, dat_s;

  rx_state_t     rx_q, rx_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic          byte_vld_q, byte_vld_d, frame_err_q, frame_err_d;
  logic [7:0]    rx_byte_q, rx_byte_d;

  pf_state_t     pf_q, pf_d;
  logic [2:0]    skip_q, skip_d;
  logic          make_ev, brk_ev, pause_ev, ev_ext;

  logic [8:0]    mapped;
  logic          ack;
  logic          rd_prev_q, rd_prev_d;
  logic [7:0]    data_q, data_d;
  logic          avail_q, avail_d, ar2_q, ar2_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          keydown_q, keydown_d, alt_q, alt_d;
  logic          stop_q, stop_d, pause_q, pause_d;

  function automatic logic [8:0] map_code(input logic [7:0] sc, input logic ext);
    map_code = 9'd0;
    if (ext) begin
      case (sc)
        8'h6B: map_code = {1'b1, 8'o010};
        8'h74: map_code = {1'b1, 8'o031};
        8'h75: map_code = {1'b1, 8'o032};
        8'h72: map_code = {1'b1, 8'o033};
        default: map_code = 9'd0;
      endcase
    end else begin
      case (sc)
        8'h1C: map_code = {1'b1, 8'o101};  8'h32: map_code = {1'b1, 8'o102};
        8'h21: map_code = {1'b1, 8'o103};  8'h23: map_code = {1'b1, 8'o104};
        8'h24: map_code = {1'b1, 8'o105};  8'h2B: map_code = {1'b1, 8'o106};
        8'h34: map_code = {1'b1, 8'o107};  8'h33: map_code = {1'b1, 8'o110};
        8'h43: map_code = {1'b1, 8'o111};  8'h3B: map_code = {1'b1, 8'o112};
        8'h42: map_code = {1'b1, 8'o113};  8'h4B: map_code = {1'b1, 8'o114};
        8'h3A: map_code = {1'b1, 8'o115};  8'h31: map_code = {1'b1, 8'o116};
        8'h44: map_code = {1'b1, 8'o117};  8'h4D: map_code = {1'b1, 8'o120};
        8'h15: map_code = {1'b1, 8'o121};  8'h2D: map_code = {1'b1, 8'o122};
        8'h1B: map_code = {1'b1, 8'o123};  8'h2C: map_code = {1'b1, 8'o124};
        8'h3C: map_code = {1'b1, 8'o125};  8'h2A: map_code = {1'b1, 8'o126};
        8'h1D: map_code = {1'b1, 8'o127};  8'h22: map_code = {1'b1, 8'o130};
        8'h35: map_code = {1'b1, 8'o131};  8'h1A: map_code = {1'b1, 8'o132};
        8'h45: map_code = {1'b1, 8'o060};  8'h16: map_code = {1'b1, 8'o061};
        8'h1E: map_code = {1'b1, 8'o062};  8'h26: map_code = {1'b1, 8'o063};
        8'h25: map_code = {1'b1, 8'o064};  8'h2E: map_code = {1'b1, 8'o065};
        8'h36: map_code = {1'b1, 8'o066};  8'h3D: map_code = {1'b1, 8'o067};
        8'h3E: map_code = {1'b1, 8'o070};  8'h46: map_code = {1'b1, 8'o071};
        8'h5A: map_code = {1'b1, 8'o012};  8'h29: map_code = {1'b1, 8'o040};
        8'h66: map_code = {1'b1, 8'o030};  8'h0D: map_code = {1'b1, 8'o015};
        default: map_code = 9'd0;
      endcase
    end
  endfunction

  // The clock is only trusted after FILTER_LEN consecutive samples disagree with the filtered level.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall  = filt_q & ~filt_d;
    dat_s = dat_sync_q[1];
  end

  assign tmo_hit = (rx_q != R_IDLE) && (tmo_q == TW'(TIMEOUT));

  always_ff @(posedge m_clock or negedge reset_n) begin
    if (!reset_n) rx_q <= R_IDLE;
    else if (ce)  rx_q <= rx_d;
  end

  always_comb begin
    rx_d = rx_q;
    case (rx_q)
      R_IDLE:  if (fall && !dat_s) rx_d = R_BITS;
      R_BITS:  if (tmo_hit) rx_d = R_IDLE;
               else if (fall && bit_cnt_q == 4'd8) rx_d = R_STOP;
      R_STOP:  if (tmo_hit || fall) rx_d = R_IDLE;
      default: rx_d = R_IDLE;
    endcase
  end

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_byte_d   = rx_byte_q;
    if (rx_q == R_IDLE || fall)      tmo_d = '0;
    else if (tmo_q != TW'(TIMEOUT))  tmo_d = tmo_q + 1'b1;
    else                             tmo_d = tmo_q;
    case (rx_q)
      R_IDLE: begin
        bit_cnt_d = 4'd0;
        if (fall && dat_s) frame_err_d = 1'b1;
      end
      R_BITS: begin
        if (tmo_hit) frame_err_d = 1'b1;
        else if (fall) begin
          shift_d   = {dat_s, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (tmo_hit) frame_err_d = 1'b1;
        else if (fall) begin
          if (dat_s && (^shift_q)) begin
            byte_vld_d = 1'b1;
            rx_byte_d  = shift_q[7:0];
          end else frame_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge m_clock or negedge reset_n) begin
    if (!reset_n) pf_q <= P_NONE;
    else if (ce)  pf_q <= pf_d;
  end

  always_comb begin
    pf_d = pf_q;
    if (byte_vld_q && skip_q == 3'd0) begin
      case (pf_q)
        P_NONE:  if (rx_byte_q == 8'hE0) pf_d = P_EXT;
                 else if (rx_byte_q == 8'hF0) pf_d = P_BRK;
        P_EXT:   pf_d = (rx_byte_q == 8'hF0) ? P_EXTBRK : P_NONE;
        default: pf_d = P_NONE;
      endcase
    end
  end

  // Pause (E1) sends no break; its seven trailing bytes are swallowed by skip_q.
  always_comb begin
    make_ev  = 1'b0;
    brk_ev   = 1'b0;
    pause_ev = 1'b0;
    ev_ext   = (pf_q == P_EXT) || (pf_q == P_EXTBRK);
    skip_d   = skip_q;
    if (byte_vld_q) begin
      if (skip_q != 3'd0) skip_d = skip_q - 1'b1;
      else begin
        case (pf_q)
          P_NONE: begin
            if (rx_byte_q == 8'hE1) begin
              pause_ev = 1'b1;
              skip_d   = 3'd7;
            end else if (rx_byte_q != 8'hE0 && rx_byte_q != 8'hF0) make_ev = 1'b1;
          end
          P_EXT:   make_ev = (rx_byte_q != 8'hF0);
          default: brk_ev  = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    mapped    = map_code(rx_byte_q, ev_ext);
    rd_prev_d = read_kbd;
    ack       = read_kbd & ~rd_prev_q;
    data_d    = data_q;
    avail_d   = avail_q;
    ar2_d     = ar2_q;
    cnt_d     = cnt_q;
    alt_d     = alt_q;
    stop_d    = stop_q;
    pause_d   = pause_q;
    if (make_ev && mapped[8]) begin
      if (!avail_q && !ack) begin
        data_d  = mapped[7:0];
        ar2_d   = alt_q;
        avail_d = 1'b1;
      end
      if (cnt_q != 3'd7) cnt_d = cnt_q + 1'b1;
    end
    if (brk_ev && mapped[8] && cnt_q != 3'd0) cnt_d = cnt_q - 1'b1;
    if (ack) avail_d = 1'b0;
    if (rx_byte_q == 8'h11 && make_ev) alt_d = 1'b1;
    if (rx_byte_q == 8'h11 && brk_ev)  alt_d = 1'b0;
    if (make_ev && !ev_ext && rx_byte_q == 8'h07) stop_d = 1'b1;
    if (brk_ev && (pause_q || (!ev_ext && rx_byte_q == 8'h07))) begin
      stop_d  = 1'b0;
      pause_d = 1'b0;
    end
    if (pause_ev) begin
      stop_d  = 1'b1;
      pause_d = 1'b1;
    end
    keydown_d = (cnt_d != 3'd0);
  end

  always_ff @(posedge m_clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_byte_q   <= '0;
      skip_q      <= '0;
      rd_prev_q   <= 1'b0;
      data_q      <= '0;
      avail_q     <= 1'b0;
      ar2_q       <= 1'b0;
      cnt_q       <= '0;
      keydown_q   <= 1'b0;
      alt_q       <= 1'b0;
      stop_q      <= 1'b0;
      pause_q     <= 1'b0;
    end else if (ce) begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      rx_byte_q   <= rx_byte_d;
      skip_q      <= skip_d;
      rd_prev_q   <= rd_prev_d;
      data_q      <= data_d;
      avail_q     <= avail_d;
      ar2_q       <= ar2_d;
      cnt_q       <= cnt_d;
      keydown_q   <= keydown_d;
      alt_q       <= alt_d;
      stop_q      <= stop_d;
      pause_q     <= pause_d;
    end
  end

  assign kbd_data      = data_q;
  assign kbd_available = avail_q;
  assign kbd_ar2       = ar2_q;
  assign stopkey       = stop_q;
  assign keydown       = keydown_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_bk_ps2_keyboard.sv
// Directed bench for bk_ps2_keyboard: bit-banged PS/2 frames with hand-computed BK codes.
module tb_bk_ps2_keyboard;
  logic       m_clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       read_kbd = 1'b0;
  logic [7:0] kbd_data;
  logic       kbd_available, kbd_ar2, stopkey, keydown, frame_err;

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0;

  bk_ps2_keyboard #(.FILTER_LEN(4), .TIMEOUT(2047)) dut (
    .m_clock(m_clock), .reset_n(reset_n), .ce(ce),
    .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .read_kbd(read_kbd),
    .kbd_data(kbd_data), .kbd_available(kbd_available), .kbd_ar2(kbd_ar2),
    .stopkey(stopkey), .keydown(keydown), .frame_err(frame_err)
  );

  always #5 m_clock = ~m_clock;

  always @(negedge m_clock) if (frame_err) ferr_cnt++;

  task automatic ps2_bit(input logic b);
    @(negedge m_clock); ps2_dat = b;
    repeat (8) @(negedge m_clock); ps2_clk = 1'b0;
    repeat (12) @(negedge m_clock); ps2_clk = 1'b1;
    repeat (10) @(negedge m_clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (20) @(negedge m_clock);
  endtask

  task automatic send_make(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic send_break(input logic [7:0] b);
    send_byte(8'hF0, 1'b0);
    send_byte(b, 1'b0);
  endtask

  task automatic pulse_read;
    @(negedge m_clock); read_kbd = 1'b1;
    repeat (3) @(negedge m_clock); read_kbd = 1'b0;
    repeat (3) @(negedge m_clock);
  endtask

  task automatic test_reset;
    logic [12:0] outs;
    reset_n = 1'b0;
    repeat (3) @(negedge m_clock);
    outs = {kbd_data, kbd_available, kbd_ar2, stopkey, keydown, frame_err};
    checks++; if (outs !== 13'd0) begin errors++; $display("FAIL reset_outs got %h want 0", outs); end
    reset_n = 1'b1;
    repeat (20) @(negedge m_clock);
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL reset_idle_ferr got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_make_a;
    send_make(8'h1C);
    checks++; if (kbd_data !== 8'o101) begin errors++; $display("FAIL a_data got %o want 101", kbd_data); end
    checks++; if (kbd_available !== 1'b1) begin errors++; $display("FAIL a_avail got %b want 1", kbd_available); end
    checks++; if (keydown !== 1'b1) begin errors++; $display("FAIL a_keydown got %b want 1", keydown); end
    checks++; if (kbd_ar2 !== 1'b0) begin errors++; $display("FAIL a_ar2 got %b want 0", kbd_ar2); end
    pulse_read;
    checks++; if (kbd_available !== 1'b0) begin errors++; $display("FAIL a_ack_avail got %b want 0", kbd_available); end
    checks++; if (kbd_data !== 8'o101) begin errors++; $display("FAIL a_ack_data got %o want 101", kbd_data); end
    send_break(8'h1C);
    checks++; if (keydown !== 1'b0) begin errors++; $display("FAIL a_release got %b want 0", keydown); end
  endtask

  task automatic test_alt;
    send_make(8'h11);
    send_make(8'h2D);
    checks++; if (kbd_data !== 8'o122) begin errors++; $display("FAIL alt_r_data got %o want 122", kbd_data); end
    checks++; if (kbd_ar2 !== 1'b1) begin errors++; $display("FAIL alt_r_ar2 got %b want 1", kbd_ar2); end
    send_break(8'h11);
    checks++; if (kbd_ar2 !== 1'b1) begin errors++; $display("FAIL alt_rel_ar2 got %b want 1", kbd_ar2); end
    pulse_read;
    send_break(8'h2D);
    checks++; if (keydown !== 1'b0) begin errors++; $display("FAIL alt_r_release got %b want 0", keydown); end
    send_make(8'h1C);
    checks++; if ({kbd_data, kbd_ar2} !== {8'o101, 1'b0}) begin errors++; $display("FAIL alt_cleared got %o/%b want 101/0", kbd_data, kbd_ar2); end
    pulse_read;
    send_break(8'h1C);
  endtask

  task automatic test_ext_arrow;
    send_make(8'hE0);
    send_make(8'h6B);
    checks++; if (kbd_data !== 8'o010) begin errors++; $display("FAIL left_data got %o want 010", kbd_data); end
    checks++; if (keydown !== 1'b1) begin errors++; $display("FAIL left_keydown got %b want 1", keydown); end
    pulse_read;
    checks++; if (kbd_available !== 1'b0) begin errors++; $display("FAIL left_ack got %b want 0", kbd_available); end
    send_make(8'hE0);
    send_break(8'h6B);
    checks++; if (keydown !== 1'b0) begin errors++; $display("FAIL left_release got %b want 0", keydown); end
    send_make(8'h6B);
    checks++; if (kbd_available !== 1'b0) begin errors++; $display("FAIL kp4_unmapped got %b want 0", kbd_available); end
    send_break(8'h6B);
  endtask

  task automatic test_no_overwrite;
    send_make(8'h16);
    send_make(8'h1E);
    checks++; if (kbd_data !== 8'o061) begin errors++; $display("FAIL held_data got %o want 061", kbd_data); end
    @(negedge m_clock); read_kbd = 1'b1;
    repeat (3) @(negedge m_clock);
    checks++; if (kbd_available !== 1'b0) begin errors++; $display("FAIL raise_ack got %b want 0", kbd_available); end
    send_make(8'h1E);
    checks++; if ({kbd_data, kbd_available} !== {8'o062, 1'b1}) begin errors++; $display("FAIL reload_data got %o/%b want 062/1", kbd_data, kbd_available); end
    read_kbd = 1'b0;
    pulse_read;
    send_break(8'h16);
    send_break(8'h1E);
    checks++; if (keydown !== 1'b1) begin errors++; $display("FAIL repeat_count got %b want 1", keydown); end
    send_break(8'h1E);
    checks++; if (keydown !== 1'b0) begin errors++; $display("FAIL repeat_release got %b want 0", keydown); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 9; i++) send_make(8'h1C);
    pulse_read;
    for (int i = 0; i < 6; i++) send_break(8'h1C);
    checks++; if (keydown !== 1'b1) begin errors++; $display("FAIL sat_six got %b want 1", keydown); end
    send_break(8'h1C);
    checks++; if (keydown !== 1'b0) begin errors++; $display("FAIL sat_seven got %b want 0", keydown); end
    send_break(8'h1C);
    checks++; if (keydown !== 1'b0) begin errors++; $display("FAIL sat_underflow got %b want 0", keydown); end
  endtask

  task automatic test_errors;
    int base;
    int waited;
    base = ferr_cnt;
    send_byte(8'h1C, 1'b1);
    checks++; if (ferr_cnt - base !== 1) begin errors++; $display("FAIL parity_ferr got %0d want 1", ferr_cnt - base); end
    checks++; if ({kbd_available, keydown} !== 2'b00) begin errors++; $display("FAIL parity_nocode got %b want 00", {kbd_available, keydown}); end
    base = ferr_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (1500) @(negedge m_clock);
    checks++; if (ferr_cnt - base !== 0) begin errors++; $display("FAIL timeout_early got %0d want 0", ferr_cnt - base); end
    waited = 0;
    while (ferr_cnt == base && waited < 800) begin
      @(negedge m_clock); waited++;
    end
    checks++; if (ferr_cnt - base !== 1) begin errors++; $display("FAIL timeout_ferr got %0d want 1", ferr_cnt - base); end
    send_make(8'h24);
    checks++; if ({kbd_data, kbd_available} !== {8'o105, 1'b1}) begin errors++; $display("FAIL after_timeout got %o/%b want 105/1", kbd_data, kbd_available); end
    pulse_read;
    send_break(8'h24);
  endtask

  task automatic test_stopkey;
    send_make(8'h07);
    checks++; if ({stopkey, kbd_available} !== 2'b10) begin errors++; $display("FAIL f12_make got %b want 10", {stopkey, kbd_available}); end
    send_break(8'h07);
    checks++; if (stopkey !== 1'b0) begin errors++; $display("FAIL f12_break got %b want 0", stopkey); end
    send_make(8'hE1); send_make(8'h14); send_make(8'h77);
    send_make(8'hE1); send_make(8'hF0); send_make(8'h14);
    send_make(8'hF0); send_make(8'h77);
    checks++; if ({stopkey, kbd_available, keydown} !== 3'b100) begin errors++; $display("FAIL pause got %b want 100", {stopkey, kbd_available, keydown}); end
    send_break(8'h1C);
    checks++; if (stopkey !== 1'b0) begin errors++; $display("FAIL pause_clear got %b want 0", stopkey); end
  endtask

  task automatic test_reset_mid;
    logic [12:0] outs;
    int base;
    send_make(8'h1C);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge m_clock); reset_n = 1'b0;
    #1;
    outs = {kbd_data, kbd_available, kbd_ar2, stopkey, keydown, frame_err};
    checks++; if (outs !== 13'd0) begin errors++; $display("FAIL midreset_outs got %h want 0", outs); end
    base = ferr_cnt;
    repeat (3) @(negedge m_clock); reset_n = 1'b1;
    repeat (2200) @(negedge m_clock);
    checks++; if (ferr_cnt - base !== 0) begin errors++; $display("FAIL midreset_ferr got %0d want 0", ferr_cnt - base); end
    send_make(8'h1C);
    checks++; if ({kbd_data, kbd_available, keydown} !== {8'o101, 2'b11}) begin errors++; $display("FAIL midreset_next got %o/%b want 101/11", kbd_data, {kbd_available, keydown}); end
  endtask

  initial begin
    test_reset;
    test_make_a;
    test_alt;
    test_ext_arrow;
    test_no_overwrite;
    test_saturation;
    test_errors;
    test_stopkey;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bk_ps2_keyboard.md
Name: bk_ps2_keyboard

Overview:
- PS/2 keyboard front-end feeding the BK core's keyboard register interface: kbd_data, kbd_available, kbd_ar2, stopkey, keydown.
- Receives PS/2 frames and tracks E0 (extended) and F0 (break) prefixes.
- Maps set-2 scancodes to BK key codes and holds one pending code until the core reads the keyboard data register (read_kbd).

Parameters:
- FILTER_LEN, 4: consecutive identical synchronized ps2_clk samples (on ce) required to accept a level change.
- TIMEOUT, 2047: ce-cycles without a filtered falling edge before a partial frame is discarded.

Ports:
- m_clock in 1: system clock.
- reset_n in 1: asynchronous reset, active-low.
- ce in 1: clock enable; all state advances only when ce=1.
- ps2_clk in 1: raw PS/2 clock, asynchronous.
- ps2_dat in 1: raw PS/2 data, asynchronous.
- read_kbd in 1: core's keyboard data register select; a rising edge acknowledges the pending code.
- kbd_data out 8: pending BK key code.
- kbd_available out 1: a code is pending.
- kbd_ar2 out 1: AR2 (Alt) was held when the pending code was captured.
- stopkey out 1: level; STOP key (F12 or Pause) is held.
- keydown out 1: at least one mapped key is held.
- frame_err out 1: one-ce pulse on a parity, start or stop error, or on a timeout.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; receiver IDLE; prefix state NONE; held-key counter 0; alt=0; filtered clock=1.
- Sync: ps2_clk and ps2_dat each pass through a 2-FF synchronizer, then ps2_clk is filtered. The filtered level changes only after FILTER_LEN equal samples.
- Receiver FSM:
  - IDLE → BITS on a filtered falling edge with dat=0 (start bit). A start bit of 1 → frame_err, stay IDLE.
  - BITS: sample 8 data bits LSB first, then the parity bit, on successive falling edges.
  - STOP: sample the stop bit. If stop=1 and the parity over data+parity is odd, emit byte_valid for one ce; otherwise pulse frame_err. Return to IDLE in either case.
  - Timeout counter resets on every falling edge. When it reaches TIMEOUT in any non-IDLE state: return to IDLE, pulse frame_err, discard bits.
- Prefix FSM, driven by byte_valid:
  - NONE: E0→EXT; F0→BRK; other bytes → make(code, ext=0).
  - EXT: F0→EXTBRK; other bytes → make(code, ext=1), then NONE.
  - BRK: byte → break(code, ext=0), then NONE.
  - EXTBRK: byte → break(code, ext=1), then NONE.
  - E1 (Pause) is treated as the make of STOP and its 7 trailing bytes are swallowed by a 3-bit skip counter. No break is generated for Pause; stopkey is cleared on the next break of any key.
- Map (non-ext unless noted; unmapped codes are ignored except for modifier tracking):
  - A–Z → 0101–0132 (octal).
  - 0–9 → 060–071.
  - Enter 5A → 012.
  - Space 29 → 040.
  - Backspace 66 → 030.
  - Tab 0D → 015.
  - Ext arrows: left 6B → 010, right 74 → 031, up 75 → 032, down 72 → 033.
  - Alt 11 (ext or not) sets/clears alt; it produces no code.
  - F12 07 sets stopkey on make and clears it on break; it produces no code.
- Make of a mapped key:
  - If kbd_available=0: kbd_data ← code, kbd_ar2 ← alt, kbd_available ← 1, all in the same ce.
  - If kbd_available=1: the code is dropped (no overwrite) and kbd_data is unchanged.
  - Counter ← min(counter+1, 7).
  - Typematic repeats are indistinguishable from makes: they reload kbd_data when empty, and the counter still saturates at 7.
- Break of a mapped key: counter ← max(counter−1, 0). keydown = (counter≠0), registered.
- Acknowledge: read_kbd is sampled each ce. On a 0→1 transition, kbd_available ← 0; kbd_data and kbd_ar2 hold their values.
  - If a make and an acknowledge occur in the same ce, the acknowledge wins and the make's code is dropped.
- Reset mid-frame: the partial frame is lost and no frame_err is generated.

Test Plan:
- Frame 1C (A) with correct odd parity, stop=1 → kbd_data=0101, kbd_available=1, keydown=1, kbd_ar2=0.
- Bytes 11, 2D (Alt+R) → kbd_data=0122, kbd_ar2=1. Then F0 11 → alt=0, and kbd_ar2 stays 1 until the next capture.
- E0 6B with kbd_available=0 → kbd_data=010. Pulse read_kbd → kbd_available=0, then E0 F0 6B → keydown=0.
- Press 16 (code 061) and leave it unread, then send 1E → kbd_data stays 061. Raise read_kbd, then send 1E → kbd_data=062.
- Frame 1C with a parity bit error → frame_err pulse, no code, kbd_available unchanged. Stop after 5 bits and idle TIMEOUT ce → frame_err, and the next good frame decodes correctly.
- Send 07 → stopkey=1, then F0 07 → stopkey=0. Assert reset_n=0 mid-frame → all outputs 0 immediately.
